sram_port_arb: RTL and testbench

Arbiter and initializer placed directly upstream of an SRAM array wrapper's single RW0 port. After reset it zero-fills the whole array. It then multiplexes two requesters onto the port: the core cache port, which normally has priority, and a Caravel Wishbone slave port used for debug and boot loading. Starvation of the Wishbone port is bounded.

---
 rtl/sram_port_arb.sv | 170 +++++++++++++++++
 tb/tb_sram_port_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arb.sv
// Single-port SRAM front end: zero-fills the array after reset, then arbitrates
// the core cache port against a Wishbone slave with bounded Wishbone starvation.
module sram_port_arb #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MASK_W       = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset_n,

    input  logic              core_en,
    input  logic              core_wmode,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [MASK_W-1:0] core_wmask,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ready,
    output logic [DATA_W-1:0] core_rdata,

    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [MASK_W-1:0] wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic              wbs_ack_o,

    output logic              init_done,

    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        WB_IDLE,
        WB_RD,
        WB_ACK
    } wb_state_e;

    logic              clear_active_q, clear_active_d;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    wb_state_e         wb_state_q, wb_state_d;
    logic              wb_ack_q, wb_ack_d;
    logic [DATA_W-1:0] wb_dat_q, wb_dat_d;

    logic              wb_req;
    logic              wb_grant;
    logic              core_grant;
    logic              starved;
    logic [ADDR_W-1:0] wb_word;
    logic              unused_adr_bits;

    assign wb_word         = wbs_adr_i[ADDR_W+1:2];
    assign unused_adr_bits = ^{wbs_adr_i[31:ADDR_W+2], wbs_adr_i[1:0]};

    // Sweep starts one cycle after release so RW0_en is never driven during reset.
    always_comb begin
        clear_active_d = clear_active_q;
        init_done_d    = init_done_q;
        clr_addr_d     = clr_addr_q;
        if (clear_active_q) begin
            clr_addr_d = clr_addr_q + 1'b1;
            if (clr_addr_q == '1) begin
                clear_active_d = 1'b0;
                init_done_d    = 1'b1;
            end
        end else if (!init_done_q) begin
            clear_active_d = 1'b1;
        end
    end

    always_comb begin
        starved    = (starve_q == CNT_W'(STARVE_LIMIT));
        wb_req     = wbs_cyc_i & wbs_stb_i & (wb_state_q == WB_IDLE) & ~wb_ack_q;
        wb_grant   = init_done_q & wb_req & (~core_en | starved);
        core_ready = init_done_q & ~wb_grant;
        core_grant = core_en & core_ready;
    end

    always_comb begin
        starve_d = starve_q;
        if (wb_grant) begin
            starve_d = '0;
        end else if (init_done_q && wb_req && core_en && !starved) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = 1'b0;
        RW0_addr  = '0;
        RW0_wmask = '0;
        RW0_wdata = '0;
        if (clear_active_q) begin
            RW0_en    = 1'b1;
            RW0_wmode = 1'b1;
            RW0_addr  = clr_addr_q;
            RW0_wmask = '1;
            RW0_wdata = '0;
        end else if (wb_grant) begin
            RW0_en    = 1'b1;
            RW0_wmode = wbs_we_i;
            RW0_addr  = wb_word;
            RW0_wmask = wbs_we_i ? wbs_sel_i : '0;
            RW0_wdata = wbs_dat_i;
        end else if (core_grant) begin
            RW0_en    = 1'b1;
            RW0_wmode = core_wmode;
            RW0_addr  = core_addr;
            RW0_wmask = core_wmask;
            RW0_wdata = core_wdata;
        end
    end

    // Read data arrives the cycle after the grant; ack follows once captured.
    always_comb begin
        wb_state_d = wb_state_q;
        wb_dat_d   = wb_dat_q;
        case (wb_state_q)
            WB_IDLE: begin
                if (wb_grant) begin
                    wb_state_d = wbs_we_i ? WB_ACK : WB_RD;
                end
            end
            WB_RD: begin
                wb_dat_d   = RW0_rdata;
                wb_state_d = WB_ACK;
            end
            WB_ACK:  wb_state_d = WB_IDLE;
            default: wb_state_d = WB_IDLE;
        endcase
        wb_ack_d = (wb_state_d == WB_ACK);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clear_active_q <= 1'b0;
            init_done_q    <= 1'b0;
            clr_addr_q     <= '0;
            starve_q       <= '0;
            wb_state_q     <= WB_IDLE;
            wb_ack_q       <= 1'b0;
            wb_dat_q       <= '0;
        end else begin
            clear_active_q <= clear_active_d;
            init_done_q    <= init_done_d;
            clr_addr_q     <= clr_addr_d;
            starve_q       <= starve_d;
            wb_state_q     <= wb_state_d;
            wb_ack_q       <= wb_ack_d;
            wb_dat_q       <= wb_dat_d;
        end
    end

    assign init_done  = init_done_q;
    assign wbs_ack_o  = wb_ack_q;
    assign wbs_dat_o  = wb_dat_q;
    assign core_rdata = RW0_rdata;

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: array model behind RW0, cycle-level reference model
// derived from the arbitration rules, and directed scenarios with literal checks.
module tb_sram_port_arb;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned MW    = 4;
    localparam int unsigned SL    = 8;
    localparam int unsigned DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          core_en = 1'b0, core_wmode = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [MW-1:0] core_wmask = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_ready;
    logic [DW-1:0] core_rdata;
    logic          wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
    logic [MW-1:0] wbs_sel_i = '0;
    logic [31:0]   wbs_adr_i = '0;
    logic [DW-1:0] wbs_dat_i = '0;
    logic [DW-1:0] wbs_dat_o;
    logic          wbs_ack_o;
    logic          init_done;
    logic          RW0_en, RW0_wmode;
    logic [AW-1:0] RW0_addr;
    logic [MW-1:0] RW0_wmask;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    always #5 clock = ~clock;

    sram_port_arb #(
        .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .STARVE_LIMIT(SL)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .core_en(core_en), .core_wmode(core_wmode), .core_addr(core_addr),
        .core_wmask(core_wmask), .core_wdata(core_wdata),
        .core_ready(core_ready), .core_rdata(core_rdata),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o),
        .init_done(init_done),
        .RW0_en(RW0_en), .RW0_wmode(RW0_wmode), .RW0_addr(RW0_addr),
        .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                            input logic [DW-1:0] new_v,
                                            input logic [MW-1:0] mask);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < MW; b++) if (mask[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    // Array behind the port: one-cycle read latency, masked writes.
    logic [DW-1:0] sram [DEPTH];
    logic [DW-1:0] sram_rd = '0;
    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) sram[RW0_addr] <= merge(sram[RW0_addr], RW0_wdata, RW0_wmask);
            else sram_rd <= sram[RW0_addr];
        end
    end
    assign RW0_rdata = sram_rd;

    // Reference model: n counts clock edges since release; the sweep writes
    // word n-1 for n in 1..DEPTH and init_done holds from n = DEPTH+1.
    int unsigned   n;
    int unsigned   wait_cnt;
    bit            busy;
    int unsigned   ack_at, cap_at;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_dat, m_dat_pend, m_core_rd;
    bit            core_rd_prev;

    always @(negedge clock) begin : model
        bit ie, clr, req, grant, cacc;
        int unsigned w;
        if (!reset_n) begin
            n = 0; wait_cnt = 0; busy = 0; ack_at = 0; cap_at = 0;
            m_dat = '0; core_rd_prev = 0;
            chk("rst_core_ready", core_ready, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_ack", wbs_ack_o, 0);
            chk("rst_dat_o", wbs_dat_o, 0);
            chk("rst_rw0", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, 0);
        end else begin
            ie    = (n >= DEPTH + 1);
            clr   = (n >= 1) && (n <= DEPTH);
            req   = wbs_cyc_i && wbs_stb_i && !busy;
            grant = ie && req && (!core_en || wait_cnt == SL);
            cacc  = ie && !grant && core_en;
            w     = int'(wbs_adr_i[AW+1:2]);
            chk("init_done", init_done, ie);
            chk("core_ready", core_ready, ie && !grant);
            chk("rw0_en", RW0_en, clr || grant || cacc);
            if (clr)
                chk("clr_fields", {RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                    {1'b1, AW'(n - 1), {MW{1'b1}}, {DW{1'b0}}});
            if (grant)
                chk("wb_fields", {RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                    {wbs_we_i, AW'(w), wbs_we_i ? wbs_sel_i : {MW{1'b0}}, wbs_dat_i});
            if (cacc)
                chk("core_fields", {RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata},
                    {core_wmode, core_addr, core_wmask, core_wdata});
            chk("wb_ack", wbs_ack_o, busy && n == ack_at);
            chk("wb_dat_o", wbs_dat_o, m_dat);
            if (core_rd_prev) chk("core_rdata", core_rdata, m_core_rd);

            core_rd_prev = cacc && !core_wmode;
            if (core_rd_prev) m_core_rd = m_mem[core_addr];
            if (busy && n == cap_at) m_dat = m_dat_pend;
            if (busy && n == ack_at) busy = 0;
            if (grant) begin
                busy     = 1;
                wait_cnt = 0;
                ack_at   = n + (wbs_we_i ? 1 : 2);
                cap_at   = wbs_we_i ? 0 : n + 1;
                if (wbs_we_i) m_mem[w] = merge(m_mem[w], wbs_dat_i, wbs_sel_i);
                else m_dat_pend = m_mem[w];
            end else if (ie && req && core_en && wait_cnt < SL) begin
                wait_cnt++;
            end
            if (clr) m_mem[n - 1] = '0;
            if (cacc && core_wmode) m_mem[core_addr] = merge(m_mem[core_addr], core_wdata, core_wmask);
            n++;
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Issues one Wishbone transfer, holding stb through the ack cycle.
    task automatic wb_do(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int grant_cyc, output int ack_cyc,
                         output logic [AW-1:0] grant_addr, output logic [31:0] rd,
                         output logic ready_at_ack);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_sel_i = sel; wbs_dat_i = dat;
        grant_cyc = -1; ack_cyc = -1; grant_addr = '0; rd = '0; ready_at_ack = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (grant_cyc < 0 && !core_ready) begin
                grant_cyc  = i;
                grant_addr = RW0_addr;
            end
            if (wbs_ack_o) begin
                ack_cyc      = i;
                rd           = wbs_dat_o;
                ready_at_ack = core_ready;
                break;
            end
        end
        cyc();
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    endtask

    int            first_wr, done_cyc, g, a;
    logic [AW-1:0] ga;
    logic [31:0]   rd;
    logic          rdy;
    bit            early_ready;

    initial begin
        repeat (3) cyc();
        #1 reset_n = 1'b1;

        first_wr = -1; done_cyc = -1; early_ready = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (first_wr < 0 && RW0_en) begin
                first_wr = i;
                chk("sweep_start_addr", RW0_addr, 0);
            end
            if (init_done) begin
                done_cyc = i;
                break;
            end
            if (core_ready) early_ready = 1;
        end
        chk("init_done_cycle", done_cyc - first_wr + 1, DEPTH + 1);
        chk("no_ready_in_clear", early_ready, 0);

        cyc();
        core_en = 1; core_wmode = 1; core_addr = 5; core_wmask = 4'b0011; core_wdata = 32'hDEADBEEF;
        cyc();
        core_wmode = 0; core_wmask = '0; core_wdata = '0;
        cyc();
        core_en = 0;
        @(negedge clock);
        chk("core_partial_rd", core_rdata, 32'h0000BEEF);
        cyc();

        wb_do(1'b1, 32'h20, 4'hF, 32'h12345678, g, a, ga, rd, rdy);
        chk("wb_wr_addr", ga, 8);
        chk("wb_wr_latency", a - g, 1);
        @(negedge clock);
        chk("wb_wr_ack_width", wbs_ack_o, 0);
        cyc();
        wb_do(1'b0, 32'h20, 4'hF, 32'h0, g, a, ga, rd, rdy);
        chk("wb_rd_latency", a - g, 2);
        chk("wb_rd_data", rd, 32'h12345678);
        @(negedge clock);
        chk("wb_rd_ack_width", wbs_ack_o, 0);
        cyc();

        core_en = 1; core_wmode = 0; core_addr = 3;
        wb_do(1'b1, 32'h2C, 4'hF, 32'hA5A5A5A5, g, a, ga, rd, rdy);
        chk("starve_grant_cycle", g, SL + 1);
        chk("starve_ready_after", rdy, 1);
        core_en = 0;
        cyc();

        core_en = 1; core_wmode = 1; core_addr = 9; core_wmask = 4'hF; core_wdata = 32'hCAFEF00D;
        cyc();
        core_en = 0; core_wmode = 0; core_wmask = '0; core_wdata = '0;
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h20; wbs_sel_i = 4'hF;
        @(negedge clock);
        chk("overlap_grant", core_ready, 0);
        cyc();
        core_en = 1; core_addr = 9;
        @(negedge clock);
        chk("overlap_core_acc", core_ready, 1);
        cyc();
        core_en = 0;
        @(negedge clock);
        chk("overlap_ack", wbs_ack_o, 1);
        chk("overlap_wb_data", wbs_dat_o, 32'h12345678);
        chk("overlap_core_data", core_rdata, 32'hCAFEF00D);
        cyc();
        wbs_cyc_i = 0; wbs_stb_i = 0;
        cyc();

        wb_do(1'b1, 32'hABC0_0024, 4'b0101, 32'h11223344, g, a, ga, rd, rdy);
        chk("alias_addr", ga, 9);
        cyc();
        wb_do(1'b0, 32'h24, 4'hF, 32'h0, g, a, ga, rd, rdy);
        chk("alias_merge", rd, 32'hCA22F044);
        cyc();

        reset_n = 0;
        repeat (2) cyc();
        reset_n = 1;
        g = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            if (RW0_en && RW0_addr == 7) begin
                g = i;
                break;
            end
        end
        chk("reached_addr7", g > 0, 1);
        #2 reset_n = 0;
        #1;
        chk("async_rst_rw0", {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata}, 0);
        chk("async_rst_flags", {init_done, core_ready, wbs_ack_o}, 0);
        repeat (2) cyc();
        reset_n = 1;
        first_wr = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (RW0_en) begin
                first_wr = i;
                chk("restart_addr", RW0_addr, 0);
                break;
            end
        end
        chk("restart_seen", first_wr > 0, 1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
